// File: rtl/serial_resistor_capacitor_low_pass_filter.sv
// First-order RC low-pass: y += alpha*(x - y) per audio strobe, with a Q16.16 accumulator.
// alpha is applied by a 17-cycle LSB-first shift-add multiplier.
module serial_resistor_capacitor_low_pass_filter #(
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned R            = 47000,
  parameter int unsigned C_35_SHIFTED = 1615
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam longint unsigned Dt32      = 64'h1_0000_0000 / 64'(SAMPLE_RATE);
  localparam longint unsigned Rc32      = (64'(R) * 64'(C_35_SHIFTED)) >> 3;
  localparam longint unsigned AlphaWide = (Dt32 << 16) / (Rc32 + Dt32);
  localparam logic [16:0]     Alpha     = AlphaWide[16:0];

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

  state_e             state_q, state_d;
  logic signed [49:0] mcand_q, mcand_d;
  logic signed [49:0] prod_q, prod_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [15:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic signed [32:0] diff;
  logic signed [49:0] prod_rnd;
  logic signed [49:0] prod_shift;
  logic signed [49:0] acc_sum;
  logic signed [31:0] acc_new;
  logic [32:0]        out_rnd;
  logic [16:0]        out_full;
  logic               unused_bits;

  always_comb begin
    diff       = {in[15], in, 16'h0000} - {acc_q[31], acc_q};
    prod_rnd   = prod_q + 50'sd32768;
    prod_shift = prod_rnd >>> 16;
    acc_sum    = $signed({{18{acc_q[31]}}, acc_q}) + prod_shift;
    // The filter update stays within [y, x], so the low 32 bits always hold the result.
    acc_new    = acc_sum[31:0];
    out_rnd    = {acc_new[31], acc_new} + 33'd32768;
    out_full   = out_rnd[32:16];

    state_d     = state_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (audio_clk_en && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (audio_clk_en) begin
          mcand_d   = {{17{diff[32]}}, diff};
          prod_d    = '0;
          bit_cnt_d = '0;
          state_d   = StMul;
        end
      end
      StMul: begin
        if (Alpha[bit_cnt_q]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d   = mcand_q <<< 1;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd16) begin
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_new;
        // Rounding can reach +32768 only; clamp it rather than wrap.
        if (!out_full[16] && out_full[15]) begin
          out_d = 16'sh7fff;
        end else begin
          out_d = out_full[15:0];
        end
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign unused_bits = ^{acc_sum[49:32], out_rnd[15:0]};

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      prod_q      <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule
